// File: rtl/range_reg_arbiter.sv
// range_reg_arbiter
//   Round-robin arbiter for four requesters that share one range-limited
//   4-bit data register. The winner's nibble is captured at grant time.
//   One cycle later it is either accepted (the value is stored, with
//   do_vld and ack pulses) or rejected (err pulse, err_src = winner).
//
//   Build option: define RANGE_ERR_CNT_EN to get a saturating 8-bit reject
//   counter on err_cnt. Without it, err_cnt is tied to 0 and no counter
//   register exists.
//
// Parameters
//   LIMIT    exclusive upper bound on accepted values (0..16)
// Ports
//   clk      clock, rising edge
//   rst      synchronous active-high reset
//   req      per-requester request, bit i = requester i
//   di       packed write data, requester i on di[4i+3:4i]
//   gnt      registered one-hot grant
//   ack      registered one-hot accept pulse
//   dout     shared data register ("do" is a reserved word in SystemVerilog)
//   do_vld   one-cycle pulse on each dout update
//   err      one-cycle pulse on each rejected write
//   err_src  index of the rejected requester; holds between errors
//   err_cnt  saturating reject count (0 unless RANGE_ERR_CNT_EN)
module range_reg_arbiter #(
    parameter logic [4:0] LIMIT = 5'd12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [15:0] di,
    output logic [3:0]  gnt,
    output logic [3:0]  ack,
    output logic [3:0]  dout,
    output logic        do_vld,
    output logic        err,
    output logic [1:0]  err_src,
    output logic [7:0]  err_cnt
);

    typedef enum logic {IDLE, CHECK} state_t;

    state_t     state, state_nxt;
    logic [1:0] ptr;
    logic [1:0] win;       // requester that owns the transaction in CHECK
    logic [3:0] cap;       // value captured at grant time
    logic [1:0] win_nxt;
    logic       found;
    logic [1:0] idx;
    logic       accept;

    // Round-robin search starting at ptr. The 2-bit index wraps 3->0 on its own.
    always_comb begin
        found   = 1'b0;
        win_nxt = ptr;
        idx     = ptr;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                found   = 1'b1;
                win_nxt = idx;
            end
        end
    end

    // Zero-extend so that LIMIT=16 accepts every value and LIMIT=0 accepts none.
    assign accept = ({1'b0, cap} < LIMIT);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = CHECK;
            CHECK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs and datapath. A reset during CHECK drops the
    // transaction, because reset has priority over the closing edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= 2'd0;
            win     <= 2'd0;
            cap     <= 4'd0;
            gnt     <= 4'd0;
            ack     <= 4'd0;
            dout    <= 4'd0;
            do_vld  <= 1'b0;
            err     <= 1'b0;
            err_src <= 2'd0;
        end else begin
            ack    <= 4'd0;
            do_vld <= 1'b0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        cap <= di[4*win_nxt +: 4];
                        win <= win_nxt;
                        gnt <= 4'b0001 << win_nxt;
                        ptr <= win_nxt + 2'd1;
                    end else begin
                        gnt <= 4'd0;
                    end
                end
                CHECK: begin
                    gnt <= 4'd0;
                    if (accept) begin
                        dout   <= cap;
                        do_vld <= 1'b1;
                        ack    <= 4'b0001 << win;
                    end else begin
                        err     <= 1'b1;
                        err_src <= win;
                    end
                end
                default: gnt <= 4'd0;
            endcase
        end
    end

`ifdef RANGE_ERR_CNT_EN
    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= 8'd0;
        else if (state == CHECK && !accept && cnt != 8'hFF)
            cnt <= cnt + 8'd1;
    end

    assign err_cnt = cnt;
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_range_reg_arbiter.sv
// Directed bench for range_reg_arbiter. It uses a main instance with
// LIMIT=12 and two boundary instances (LIMIT=0, LIMIT=16) that share the
// same stimulus.
module tb_range_reg_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] di;

    logic [3:0] gnt, ack, dout;
    logic       do_vld, err;
    logic [1:0] err_src;
    logic [7:0] err_cnt;

    logic [3:0] z_gnt, z_ack, z_dout;
    logic       z_vld, z_err;
    logic [1:0] z_src;
    logic [7:0] z_cnt;

    logic [3:0] f_gnt, f_ack, f_dout;
    logic       f_vld, f_err;
    logic [1:0] f_src;
    logic [7:0] f_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    range_reg_arbiter #(.LIMIT(5'd12)) dut (
        .clk(clk), .rst(rst), .req(req), .di(di),
        .gnt(gnt), .ack(ack), .dout(dout), .do_vld(do_vld),
        .err(err), .err_src(err_src), .err_cnt(err_cnt));

    range_reg_arbiter #(.LIMIT(5'd0)) dut_z (
        .clk(clk), .rst(rst), .req(req), .di(di),
        .gnt(z_gnt), .ack(z_ack), .dout(z_dout), .do_vld(z_vld),
        .err(z_err), .err_src(z_src), .err_cnt(z_cnt));

    range_reg_arbiter #(.LIMIT(5'd16)) dut_f (
        .clk(clk), .rst(rst), .req(req), .di(di),
        .gnt(f_gnt), .ack(f_ack), .dout(f_dout), .do_vld(f_vld),
        .err(f_err), .err_src(f_src), .err_cnt(f_cnt));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] cnt_exp(input logic [7:0] on_val);
`ifdef RANGE_ERR_CNT_EN
        return on_val;
`else
        return on_val & 8'h00;
`endif
    endfunction

    typedef struct {
        logic [3:0]  req;
        logic [15:0] di;
        logic [3:0]  gnt;
        logic [3:0]  dout;
        logic [3:0]  ack;
        logic        vld;
        logic        err;
        logic [1:0]  src;
        logic [7:0]  cnt;    // expected count with the counter enabled
        logic        close;  // this edge closes a CHECK
    } vec_t;

    vec_t tbl [14];
    int   errs;

    initial begin
        tbl[0]  = '{4'h1, 16'h0005, 4'h1, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0};
        tbl[1]  = '{4'h0, 16'h0000, 4'h0, 4'h5, 4'h1, 1'b1, 1'b0, 2'd0, 8'd0, 1'b1};
        tbl[2]  = '{4'h1, 16'h000C, 4'h1, 4'h5, 4'h0, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0};
        tbl[3]  = '{4'h0, 16'h0000, 4'h0, 4'h5, 4'h0, 1'b0, 1'b1, 2'd0, 8'd1, 1'b1};
        tbl[4]  = '{4'h1, 16'h000B, 4'h1, 4'h5, 4'h0, 1'b0, 1'b0, 2'd0, 8'd1, 1'b0};
        tbl[5]  = '{4'h0, 16'h0000, 4'h0, 4'hB, 4'h1, 1'b1, 1'b0, 2'd0, 8'd1, 1'b1};
        tbl[6]  = '{4'h2, 16'h00F0, 4'h2, 4'hB, 4'h0, 1'b0, 1'b0, 2'd0, 8'd1, 1'b0};
        tbl[7]  = '{4'h0, 16'h0000, 4'h0, 4'hB, 4'h0, 1'b0, 1'b1, 2'd1, 8'd2, 1'b1};
        tbl[8]  = '{4'h3, 16'h0093, 4'h1, 4'hB, 4'h0, 1'b0, 1'b0, 2'd1, 8'd2, 1'b0};
        tbl[9]  = '{4'h3, 16'h000F, 4'h0, 4'h3, 4'h1, 1'b1, 1'b0, 2'd1, 8'd2, 1'b1};
        tbl[10] = '{4'h3, 16'h0093, 4'h2, 4'h3, 4'h0, 1'b0, 1'b0, 2'd1, 8'd2, 1'b0};
        tbl[11] = '{4'h0, 16'h0000, 4'h0, 4'h9, 4'h2, 1'b1, 1'b0, 2'd1, 8'd2, 1'b1};
        tbl[12] = '{4'h4, 16'h0000, 4'h4, 4'h9, 4'h0, 1'b0, 1'b0, 2'd1, 8'd2, 1'b0};
        tbl[13] = '{4'h0, 16'h0000, 4'h0, 4'h0, 4'h4, 1'b1, 1'b0, 2'd1, 8'd2, 1'b1};

        rst = 1'b1; req = 4'h0; di = 16'h0;
        tick(); tick();
        chk("rst_gnt", gnt, 0);  chk("rst_ack", ack, 0);
        chk("rst_do", dout, 0);  chk("rst_vld", do_vld, 0);
        chk("rst_err", err, 0);  chk("rst_src", err_src, 0);
        chk("rst_cnt", err_cnt, 0);
        rst = 1'b0;

        // Accept/reject/wrap/round-robin table on the LIMIT=12 instance,
        // with the LIMIT=0 and LIMIT=16 instances checked on every CHECK close.
        for (int i = 0; i < 14; i++) begin
            req = tbl[i].req; di = tbl[i].di;
            tick();
            chk($sformatf("v%0d_gnt", i), gnt, tbl[i].gnt);
            chk($sformatf("v%0d_do", i), dout, tbl[i].dout);
            chk($sformatf("v%0d_ack", i), ack, tbl[i].ack);
            chk($sformatf("v%0d_vld", i), do_vld, tbl[i].vld);
            chk($sformatf("v%0d_err", i), err, tbl[i].err);
            chk($sformatf("v%0d_src", i), err_src, tbl[i].src);
            chk($sformatf("v%0d_cnt", i), err_cnt, cnt_exp(tbl[i].cnt));
            chk($sformatf("v%0d_z_err", i), z_err, tbl[i].close);
            chk($sformatf("v%0d_z_vld", i), z_vld, 0);
            chk($sformatf("v%0d_f_vld", i), f_vld, tbl[i].close);
            chk($sformatf("v%0d_f_err", i), f_err, 0);
        end

        // Value 15 goes to requester 3: rejected at LIMIT=12 and LIMIT=0, accepted at LIMIT=16.
        req = 4'h8; di = 16'hF000;
        tick();
        chk("r3_gnt", gnt, 4'h8);
        req = 4'h0;
        tick();
        chk("r3_err", err, 1);      chk("r3_src", err_src, 3);
        chk("r3_do", dout, 0);      chk("r3_cnt", err_cnt, cnt_exp(8'd3));
        chk("r3_z_err", z_err, 1);  chk("r3_z_do", z_dout, 0);
        chk("r3_f_do", f_dout, 4'hF); chk("r3_f_ack", f_ack, 4'h8);

        // Fairness with all four requesters held high and ptr at 0.
        req = 4'hF; di = 16'h1111;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (i % 2 == 0) begin
                chk($sformatf("fair%0d_gnt", i), gnt, 4'b0001 << ((i / 2) % 4));
                chk($sformatf("fair%0d_ack", i), ack, 0);
            end else begin
                chk($sformatf("fair%0d_gnt", i), gnt, 0);
                chk($sformatf("fair%0d_ack", i), ack, 4'b0001 << ((i / 2) % 4));
                chk($sformatf("fair%0d_do", i), dout, 1);
            end
            chk($sformatf("fair%0d_excl", i), (ack != 0) && err, 0);
        end
        req = 4'h0;
        tick();
        chk("fair_last_ack", ack, 4'h1);

        // Reset arrives while CHECK holds value 7, so the transaction is aborted.
        req = 4'h2; di = 16'h0070;
        tick();
        chk("ab_gnt", gnt, 4'h2);
        rst = 1'b1; req = 4'h0;
        tick();
        chk("ab_ack", ack, 0);   chk("ab_do", dout, 0);
        chk("ab_vld", do_vld, 0); chk("ab_err", err, 0);
        chk("ab_gnt0", gnt, 0);  chk("ab_cnt", err_cnt, 0);
        rst = 1'b0; req = 4'h1; di = 16'h0005;
        tick();
        chk("ab_regnt", gnt, 4'h1);
        req = 4'h0;
        tick();
        chk("ab_do5", dout, 5); chk("ab_ack1", ack, 4'h1);

        // Saturation: 300 consecutive rejects.
        req = 4'h1; di = 16'h000F;
        errs = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (err) errs++;
            if ((ack != 0) && err) chk("sat_excl", 1, 0);
        end
        req = 4'h0;
        chk("sat_errs", errs, 300);
        chk("sat_cnt", err_cnt, cnt_exp(8'd255));
        chk("sat_do", dout, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/range_reg_arbiter.md
RANGE_REG_ARBITER -- requirements
Module: range_reg_arbiter

Interface
REQ-001 Parameter: LIMIT, 12, exclusive upper bound on accepted values; 5-bit, legal range 0..16.
REQ-002 Port: clk  input  1  single clock; all logic on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: req  input  4  per-requester request, bit i = requester i.
REQ-005 Port: di  input  16  packed write data; requester i on di[4i+3:4i].
REQ-006 Port: gnt  output  4  one-hot grant, registered.
REQ-007 Port: ack  output  4  one-hot accept pulse, registered.
REQ-008 Port: do  output  4  shared range-limited data register.
REQ-009 Port: do_vld  output  1  one-cycle pulse on each do update.
REQ-010 Port: err  output  1  one-cycle pulse on each rejected write.
REQ-011 Port: err_src  output  2  index of the rejected requester; valid while err=1, otherwise holds its last value.
REQ-012 Port: err_cnt  output  8  saturating reject counter.

Function
REQ-013 The FSM SHALL have two states: IDLE and CHECK.
REQ-014 In IDLE, if req!=0 the block SHALL select winner w round-robin, searching from ptr upward with wrap 3->0.
- At that edge it SHALL capture di[w] and set gnt=onehot(w), ptr=(w+1) mod 4, state=CHECK.
REQ-015 In IDLE with req==0 the block SHALL keep the state, keep ptr, and drive gnt=0.
REQ-016 In CHECK, req and di SHALL be ignored.
- At the closing edge: gnt=0, state=IDLE.
REQ-017 At the CHECK closing edge, if captured<LIMIT (unsigned, 5-bit compare):
- do=captured, do_vld=1, ack[w]=1 for one cycle.
REQ-018 At the CHECK closing edge, if captured>=LIMIT:
- do unchanged, err=1, err_src=w, no ack.
REQ-019 Latency: request sampled in cycle N -> gnt high in N+1 -> do/ack/err visible in N+2.
- Peak throughput is one transaction per 2 cycles.
REQ-020 Requester data SHALL only need to be valid in the sampling cycle.
- A req still high in the cycle after CHECK SHALL be treated as a new request.
REQ-021 Boundaries:
- LIMIT=0 SHALL reject every write.
- LIMIT=16 SHALL accept every write.
- Captured value LIMIT-1 SHALL be accepted; value LIMIT SHALL be rejected.
REQ-022 At most one of ack!=0 or err=1 SHALL be asserted in any cycle, and gnt SHALL never be non-one-hot.

Reset
REQ-023 When rst=1 at a clock edge, the block SHALL set:
- state=IDLE, ptr=0, gnt=0, ack=0
- do=0, do_vld=0, err=0, err_src=0, err_cnt=0
REQ-024 Reset asserted while in CHECK SHALL abort the transaction: no do update, no ack, no err.
REQ-025 rst SHALL take priority over all other activity in the same cycle.

Configuration
REQ-026 Macro RANGE_ERR_CNT_EN defined: err_cnt SHALL increment on each err pulse, saturating at 255.
REQ-027 Macro RANGE_ERR_CNT_EN undefined: err_cnt SHALL be constant 0 and no counter register shall be synthesized.
- All other behaviour is identical with or without the macro.

Verification
REQ-028 Accept: after reset, req=0001, di0=5.
- Required: gnt=0001 next cycle; following cycle do=5, do_vld=1, ack=0001.
REQ-029 Reject: LIMIT=12, req=0001, di0=12.
- Required: err=1, err_src=0, do stays 5, err_cnt=1 (macro on).
- Then di0=11: accepted, do=11.
REQ-030 Fairness: req=1111 held, ptr=0.
- Required: gnt sequence 0001,0010,0100,1000,0001, one grant every 2 cycles.
REQ-031 Wrap: after a grant to requester 1 (ptr=2), req=0011.
- Required: requester 0 granted next.
REQ-032 Abort: rst=1 during CHECK carrying value 7.
- Required: no ack, do=0, state IDLE next cycle.
REQ-033 Saturation: 300 consecutive rejects.
- Macro on: err_cnt=255.
- Macro off: err_cnt=0 throughout.
